// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module : demux_pkg
// Brief  : Shared constants and state type for the 1-to-8 demux / frame collector.
// Rev    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int   C_LANES     = 8;
    localparam int   C_SEL_W     = 3;
    localparam logic C_MODE_ADDR = 1'b0;
    localparam logic C_MODE_SEQ  = 1'b1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/demux1ne8_seq_dec3ne8.sv
`default_nettype none
// ============================================================================
// Module : dec3ne8
// Brief  : Combinational 3-to-8 one-hot decoder with enable (lane write strobes).
// Rev    : 1.0 - initial release
// ============================================================================
module dec3ne8
    import demux_pkg::*;
(
    input  logic [C_SEL_W-1:0] i_sel,
    input  logic               i_en,
    output logic [C_LANES-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux1ne8_seq.sv
`default_nettype none
// ============================================================================
// Module : demux1ne8_seq
// Brief  : Sequential 1-to-8 demux; collects eight lanes into a held frame.
// Rev    : 1.0 - initial release
// ============================================================================
module demux1ne8_seq
    import demux_pkg::*;
#(
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         h,
    input  logic [C_SEL_W-1:0]   cline,
    input  logic                 mode,
    input  logic                 clear,
    input  logic                 out_ack,
    output logic [C_LANES*W-1:0] lanes,
    output logic [C_LANES-1:0]   written,
    output logic                 full,
    output logic                 frame_mode
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [W-1:0]         r_lane [C_LANES];
    logic [C_LANES-1:0]   r_written;
    logic [C_SEL_W-1:0]   r_ptr;
    logic                 r_frame_mode;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_first;
    logic                 w_eff_mode;
    logic [C_SEL_W-1:0]   w_target;
    logic [C_LANES-1:0]   w_strobe;
    logic [C_LANES-1:0]   w_written_nxt;

    assign w_ready       = (r_state == ST_FILL) && !clear;
    assign w_accept      = in_valid && w_ready;
    assign w_first       = (r_written == '0);
    // The first beat of a frame already steers with the freshly sampled mode.
    assign w_eff_mode    = w_first ? mode : r_frame_mode;
    assign w_target      = (w_eff_mode == C_MODE_SEQ) ? r_ptr : cline;
    assign w_written_nxt = r_written | w_strobe;

    dec3ne8 u_dec (
        .i_sel    (w_target),
        .i_en     (w_accept),
        .o_onehot (w_strobe)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL: if (w_accept && (&w_written_nxt)) w_state_nxt = ST_FULL;
            ST_FULL: if (out_ack) w_state_nxt = ST_FILL;
        endcase
        if (clear) begin
            w_state_nxt = ST_FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FILL;
            r_written    <= '0;
            r_ptr        <= '0;
            r_frame_mode <= C_MODE_ADDR;
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_written    <= '0;
                r_ptr        <= '0;
                r_frame_mode <= C_MODE_ADDR;
            end else if (r_state == ST_FULL) begin
                if (out_ack) begin
                    r_written <= '0;
                    r_ptr     <= '0;
                end
            end else if (w_accept) begin
                r_written <= w_written_nxt;
                if (w_first) begin
                    r_frame_mode <= mode;
                end
                if (w_eff_mode == C_MODE_SEQ) begin
                    r_ptr <= r_ptr + 3'd1;
                end
            end
        end
    end

    for (genvar k = 0; k < C_LANES; k++) begin : g_lane
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lane[k] <= '0;
            end else if (w_strobe[k]) begin
                r_lane[k] <= h;
            end
        end
        assign lanes[k*W +: W] = r_lane[k];
    end

    assign in_ready   = w_ready;
    assign written    = r_written;
    assign full       = (r_state == ST_FULL);
    assign frame_mode = r_frame_mode;

endmodule
`default_nettype wire

// File: tb/tb_demux1ne8_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_demux1ne8_seq
// Brief  : Self-checking bench: vector table, directed corner cases, random vs model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_demux1ne8_seq;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  h = '0;
    logic [2:0]    cline = '0;
    logic          mode = 1'b0;
    logic          clear = 1'b0;
    logic          out_ack = 1'b0;
    logic [8*W-1:0] lanes;
    logic [7:0]    written;
    logic          full;
    logic          frame_mode;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux1ne8_seq #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .h          (h),
        .cline      (cline),
        .mode       (mode),
        .clear      (clear),
        .out_ack    (out_ack),
        .lanes      (lanes),
        .written    (written),
        .full       (full),
        .frame_mode (frame_mode)
    );

    // Frame-level reference: an array of lane values and a set of written lanes.
    logic [7:0] m_lane [8];
    bit         m_wr   [8];
    int         m_ptr;
    bit         m_full;
    bit         m_fmode;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += m_wr[i] ? 1 : 0;
        return c;
    endfunction

    function automatic logic [63:0] m_lanes_packed();
        logic [63:0] p = '0;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = m_lane[i];
        return p;
    endfunction

    function automatic logic [7:0] m_wr_packed();
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) p[i] = m_wr[i];
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_lane[i] = '0;
            m_wr[i]   = 1'b0;
        end
        m_ptr = 0; m_full = 0; m_fmode = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] hh, input int cl,
                              input bit m, input bit clr, input bit ack);
        int tgt;
        if (clr) begin
            for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
            m_ptr = 0; m_fmode = 0; m_full = 0;
        end else if (m_full) begin
            if (ack) begin
                for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
                m_ptr = 0; m_full = 0;
            end
        end else if (v) begin
            if (m_count() == 0) m_fmode = m;
            if (m_fmode) begin
                tgt   = m_ptr;
                m_ptr = (m_ptr + 1) % 8;
            end else begin
                tgt = cl;
            end
            m_lane[tgt] = hh;
            m_wr[tgt]   = 1'b1;
            if (m_count() == 8) m_full = 1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; drives inputs, checks in_ready, clocks, then checks all outputs.
    task automatic cycle(input bit v, input logic [7:0] hh, input int cl,
                         input bit m, input bit clr, input bit ack);
        in_valid = v; h = hh; cline = 3'(cl); mode = m; clear = clr; out_ack = ack;
        #1;
        chk("in_ready_pre", {63'd0, in_ready}, {63'd0, !m_full && !clr});
        model_step(v, hh, cl, m, clr, ack);
        @(posedge clk); #1;
        chk("lanes", lanes, m_lanes_packed());
        chk("written", {56'd0, written}, {56'd0, m_wr_packed()});
        chk("full", {63'd0, full}, {63'd0, m_full});
        chk("frame_mode", {63'd0, frame_mode}, {63'd0, m_fmode});
    endtask

    typedef struct {
        bit          v;
        logic [7:0]  hh;
        int          cl;
        bit          m;
        bit          clr;
        bit          ack;
        bit          rdy_post;
        logic [7:0]  wr;
        bit          fl;
        logic [63:0] ln;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, logic [7:0] hh, int cl, bit m, bit clr, bit ack,
                                bit rdy, logic [7:0] wr, bit fl, logic [63:0] ln);
        vec_t r;
        r.v = v; r.hh = hh; r.cl = cl; r.m = m; r.clr = clr; r.ack = ack;
        r.rdy_post = rdy; r.wr = wr; r.fl = fl; r.ln = ln;
        return r;
    endfunction

    initial begin
        logic [63:0] acc;
        int          seq_a [8];
        int          seq_r [9];
        logic [7:0]  val_r [9];

        seq_a = '{5, 2, 7, 0, 1, 3, 6, 4};
        seq_r = '{3, 3, 0, 1, 2, 4, 5, 6, 7};

        // Sequential frame, back-pressure while FULL, release, first beat after release.
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            acc[k*8 +: 8] = 8'(8'h10 + k);
            tbl.push_back(mk(1, 8'(8'h10 + k), 0, 1, 0, 0, k != 7,
                             8'((1 << (k + 1)) - 1), k == 7, acc));
        end
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(1, 8'hFF, 0, 1, 0, 0, 0, 8'hFF, 1, 64'h1716151413121110));
        tbl.push_back(mk(1, 8'hFF, 0, 1, 0, 1, 1, 8'h00, 0, 64'h1716151413121110));
        tbl.push_back(mk(1, 8'hFF, 0, 1, 0, 0, 1, 8'h01, 0, 64'h17161514131211FF));

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_lanes", lanes, 64'd0);
        chk("reset_written", {56'd0, written}, 64'd0);
        chk("reset_full", {63'd0, full}, 64'd0);
        chk("reset_frame_mode", {63'd0, frame_mode}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].hh, tbl[i].cl, tbl[i].m, tbl[i].clr, tbl[i].ack);
            chk($sformatf("tbl_lanes[%0d]", i), lanes, tbl[i].ln);
            chk($sformatf("tbl_written[%0d]", i), {56'd0, written}, {56'd0, tbl[i].wr});
            chk($sformatf("tbl_full[%0d]", i), {63'd0, full}, {63'd0, tbl[i].fl});
            chk($sformatf("tbl_in_ready[%0d]", i), {63'd0, in_ready}, {63'd0, tbl[i].rdy_post});
        end

        // Addressed frame after a clear (clear with valid high must not accept).
        cycle(1, 8'h55, 0, 0, 1, 0);
        chk("clear_written", {56'd0, written}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 8'(8'hA0 + seq_a[i]), seq_a[i], 0, 0, 0);
            chk($sformatf("addr_full[%0d]", i), {63'd0, full}, {63'd0, i == 7});
        end
        chk("addr_lanes", lanes, 64'hA7A6A5A4A3A2A1A0);
        cycle(0, 8'h00, 0, 0, 0, 1);

        // Rewrite of lane 3 does not count toward completion.
        for (int i = 0; i < 9; i++)
            val_r[i] = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'(8'h30 + seq_r[i]);
        for (int i = 0; i < 9; i++) begin
            cycle(1, val_r[i], seq_r[i], 0, 0, 0);
            chk($sformatf("rewr_full[%0d]", i), {63'd0, full}, {63'd0, i == 8});
        end
        chk("rewr_lane3", {56'd0, lanes[3*8 +: 8]}, 64'h22);
        cycle(0, 8'h00, 0, 0, 0, 1);

        // Clear mid-frame in sequential mode.
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'h60 + i), 0, 1, 0, 0);
        cycle(1, 8'hEE, 0, 1, 1, 0);
        chk("clr_written", {56'd0, written}, 64'd0);
        chk("clr_lane4", {56'd0, lanes[4*8 +: 8]}, 64'h34);
        cycle(1, 8'h77, 0, 1, 0, 0);
        chk("clr_next_written", {56'd0, written}, 64'h01);
        chk("clr_next_lane0", {56'd0, lanes[7:0]}, 64'h77);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h80 + i), 0, 1, 0, 0);
        in_valid = 1'b0; clear = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_lanes", lanes, 64'd0);
        chk("arst_written", {56'd0, written}, 64'd0);
        chk("arst_full", {63'd0, full}, 64'd0);
        chk("arst_frame_mode", {63'd0, frame_mode}, 64'd0);
        model_reset();
        #1 rst = 1'b0;
        cycle(1, 8'h9C, 6, 0, 0, 0);
        chk("arst_cline6", {56'd0, written}, 64'h40);

        // Randomized traffic against the frame model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), int'($urandom % 8),
                  1'($urandom % 2), ($urandom % 20) == 0, ($urandom % 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux1ne8_seq.md
# demux1ne8_seq

Sequential 1-to-8 demultiplexer and frame collector: the counterpart to the `mux8ne1` 8-to-1 selector. It accepts one W-bit value per handshake, steers it to one of eight registered output lanes, and reports a full frame once all eight lanes hold fresh data. Lanes are chosen either by an explicit 3-bit `cline` (addressed mode) or by an internal wrap-around pointer (sequential mode). It sits between a serial producer and the datapath blocks that consume eight lanes in parallel.

## Interface
- W, default 1: width of each lane and of the input word.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on `h`.
- in_ready  output  1  block can accept a word this cycle.
- h  input  W  input data word.
- cline  input  3  target lane in addressed mode; ignored in sequential mode.
- mode  input  1  0 = addressed, 1 = sequential; sampled only on the first beat of a frame.
- clear  input  1  synchronous frame abort.
- out_ack  input  1  consumer has taken the full frame.
- lanes  output  8*W  registered lanes; lane k occupies bits [k*W +: W].
- written  output  8  per-lane "written this frame" mask.
- full  output  1  all eight lanes are written and the frame is held.
- frame_mode  output  1  mode latched for the current frame.

## Operation
- States:
  - FILL: accepting words.
  - FULL: holding the frame; no words accepted.
- Reset values: state FILL, `lanes` = 0, `written` = 0, ptr = 0, `frame_mode` = 0, `full` = 0.
- `in_ready` = (state == FILL) && !clear. This is combinational from state and clear only, never from `in_valid`.
- Accept occurs when `in_valid && in_ready`.
- First beat of a frame (`written` == 0): `frame_mode` <= `mode`, and this beat already uses the new mode.
- Target lane on accept:
  - Addressed mode: target = `cline`.
  - Sequential mode: target = ptr, then ptr <= ptr + 1 (3-bit, wraps 7 -> 0).
- On accept, `lanes[target]` <= `h` and `written[target]` <= 1.
- Addressed rewrite of an already-written lane overwrites the data. `written` is unchanged, and the write does not count toward completion.
- FILL -> FULL when the accept makes `written` all ones.
  - Sequential mode: always exactly the 8th beat.
  - Addressed mode: the beat that writes the last missing lane.
- In FULL:
  - `lanes` and `written` are frozen and `full` = 1.
  - `out_ack` moves the block to FILL and clears `written` and ptr. `lanes` keep their old values until overwritten.
- `out_ack` in FILL is ignored.
- `clear` in any state:
  - Next state is FILL; `written`, ptr and `frame_mode` are cleared. `lanes` are not cleared.
  - No accept happens in the `clear` cycle.
  - `clear` wins over a simultaneous `out_ack`.
- A change of `mode` mid-frame has no effect until the next frame.
- Reset asserted mid-frame returns immediately (asynchronously) to the reset values.

## Timing
- Write latency is 1 cycle: a word accepted at edge n is visible on `lanes` and `written` after edge n.
- `full` rises on the edge that accepts the completing beat. `in_ready` is low from the next cycle.
- Release latency is 1 cycle: `out_ack` sampled high in FULL at edge n gives `full` = 0 and `in_ready` = 1 (if `clear` is low) after edge n.
- Back-to-back operation is allowed:
  - In FILL, one word can be accepted every cycle.
  - Minimum frame turnaround in sequential mode is 8 accept cycles plus 1 ack cycle.
- There are no combinational paths from `h`, `cline` or `mode` to any output.

## Structure
- Shared package `demux_pkg`:
  - State encoding constants: FILL = 1'b0, FULL = 1'b1.
  - Lane count constant: 8, with the 3-bit select width.
  - `MODE_ADDR` and `MODE_SEQ` constants.
- One natural sub-module is `dec3ne8`, a combinational 3-to-8 one-hot decoder with enable. It generates the per-lane write strobes from the selected target lane and the accept signal.
- The FSM, ptr counter and lane registers stay in the top module.

## Test plan
- Sequential frame, W=8, mode=1: 8 back-to-back beats with h = 0x10..0x17. Required:
  - `lanes` = {0x17,...,0x10}, `full` = 1 after the 8th edge.
  - `in_ready` = 0 until `out_ack`; `in_ready` = 1 one cycle after the ack.
- Addressed frame, mode=0: clines 5,2,7,0,1,3,6,4 with h = cline+0xA0. Required:
  - Each lane k holds 0xA0+k.
  - `full` rises exactly on the 8th distinct lane.
- Addressed rewrite: write lane 3 twice (0x11 then 0x22), then the other 7 lanes. Required:
  - `full` rises only after 9 accepts.
  - Lane 3 = 0x22.
- Clear mid-frame: after 4 sequential beats, assert `clear` with `in_valid` = 1. Required:
  - No accept in that cycle; `written` = 0 and ptr = 0 afterwards.
  - The next beat lands in lane 0.
- Back-pressure: hold `in_valid` = 1 with h = 0xFF while FULL for 5 cycles. Required:
  - `lanes` and `written` are unchanged.
  - After `out_ack`, the first 0xFF is accepted into lane 0.
- Reset mid-frame: assert Reset asynchronously between edges during FILL. Required:
  - All outputs go to their reset values immediately.
  - After deassertion, a mode-0 beat to cline 6 sets only `written[6]`.
